// File: rtl/tag_ctrl_pkg.sv
// Shared types for the tag memory controller: FSM state encoding and tag entry layout.
// TAG_CTRL_FLUSH_EN adds the FLUSH state to the encoding.
package tag_ctrl_pkg;

    // Widest tag the decoded entry can carry; narrower tags are zero-extended.
    localparam int unsigned TAG_W_MAX = 64;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_READY = 2'd1
`ifdef TAG_CTRL_FLUSH_EN
        ,
        ST_FLUSH = 2'd2
`endif
    } tag_ctrl_state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
    } tag_entry_t;

    function automatic logic tag_hit(input tag_entry_t entry, input logic [TAG_W_MAX-1:0] tag);
        return entry.valid && (entry.tag == tag);
    endfunction

endpackage

// File: rtl/tag_memory_controller_if.sv
// Request/response bundle between a requester (master) and the tag memory controller (slave).
interface tag_memory_controller_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int TAG_SIZE   = 20
);
    // Requests (lookup_req_i, update_req_i) are held high with stable payload until the
    // matching *_gnt_o is seen high in the same cycle; the transfer happens at that clock edge.
    // lookup_valid_o pulses exactly one cycle after each lookup grant, in grant order.
    logic                  lookup_req_i;
    logic [ADDR_WIDTH-1:0] lookup_index_i;
    logic [TAG_SIZE-1:0]   lookup_tag_i;
    logic                  lookup_gnt_o;
    logic                  lookup_valid_o;
    logic                  lookup_hit_o;
    logic                  update_req_i;
    logic [ADDR_WIDTH-1:0] update_index_i;
    logic [TAG_SIZE-1:0]   update_tag_i;
    logic                  update_invalidate_i;
    logic                  update_gnt_o;
    logic                  flush_req_i;
    logic                  flush_busy_o;
    logic                  init_done_o;

    modport master (
        output lookup_req_i, lookup_index_i, lookup_tag_i,
        output update_req_i, update_index_i, update_tag_i, update_invalidate_i,
        output flush_req_i,
        input  lookup_gnt_o, lookup_valid_o, lookup_hit_o,
        input  update_gnt_o, flush_busy_o, init_done_o
    );

    modport slave (
        input  lookup_req_i, lookup_index_i, lookup_tag_i,
        input  update_req_i, update_index_i, update_tag_i, update_invalidate_i,
        input  flush_req_i,
        output lookup_gnt_o, lookup_valid_o, lookup_hit_o,
        output update_gnt_o, flush_busy_o, init_done_o
    );

endinterface

// File: rtl/tag_memory.sv
// Tag storage: port 0 read/write, port 1 read-only, both with registered read data.
module tag_memory #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 21
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  p0_en_i,
    input  logic                  p0_we_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic [DATA_WIDTH-1:0] p0_wdata_i,
    output logic [DATA_WIDTH-1:0] p0_rdata_o,
    input  logic                  p1_en_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    output logic [DATA_WIDTH-1:0] p1_rdata_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] p0_rdata_d, p0_rdata_q;
    logic [DATA_WIDTH-1:0] p1_rdata_d, p1_rdata_q;

    // The array has no reset; the controller sweeps it clear after every reset.
    always_ff @(posedge clk_i) begin
        if (p0_en_i && p0_we_i) begin
            mem_q[p0_addr_i] <= p0_wdata_i;
        end
    end

    always_comb begin
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        if (p0_en_i && !p0_we_i) begin
            p0_rdata_d = mem_q[p0_addr_i];
        end
        if (p1_en_i) begin
            p1_rdata_d = mem_q[p1_addr_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    assign p0_rdata_o = p0_rdata_q;
    assign p1_rdata_o = p1_rdata_q;

endmodule

// File: rtl/tag_memory_controller.sv
// Tag memory controller: power-up clearing sweep, update-over-lookup arbitration, hit compare.
// Defining TAG_CTRL_FLUSH_EN enables the flush sweep triggered by flush_req_i.
module tag_memory_controller
    import tag_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int TAG_SIZE   = 20
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    tag_memory_controller_if.slave  bus,
    output tag_ctrl_state_e         state_o
);
    localparam int                    DATA_WIDTH = TAG_SIZE + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = '1;

    tag_ctrl_state_e       state_d, state_q;
    logic [ADDR_WIDTH-1:0] cnt_d, cnt_q;
    logic                  lk_valid_d, lk_valid_q;
    logic [TAG_SIZE-1:0]   lk_tag_d, lk_tag_q;

    logic                  upd_gnt;
    logic                  lk_gnt;
    logic                  flush_take;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] unused_p1_rdata;
    tag_entry_t            rd_entry;

`ifdef TAG_CTRL_FLUSH_EN
    assign flush_take = bus.flush_req_i;
`else
    logic unused_flush_req;
    assign unused_flush_req = bus.flush_req_i;
    assign flush_take       = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lk_valid_d = 1'b0;
        lk_tag_d   = lk_tag_q;
        upd_gnt    = 1'b0;
        lk_gnt     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            ST_READY: begin
                // A flush claims the cycle from a pending update; a lookup only yields to updates.
                upd_gnt = bus.update_req_i && !flush_take;
                lk_gnt  = bus.lookup_req_i && !bus.update_req_i;
`ifdef TAG_CTRL_FLUSH_EN
                if (flush_take) begin
                    state_d = ST_FLUSH;
                end
`endif
                if (upd_gnt) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = bus.update_index_i;
                    mem_wdata = bus.update_invalidate_i ? '0 : {1'b1, bus.update_tag_i};
                end else if (lk_gnt) begin
                    mem_en     = 1'b1;
                    mem_addr   = bus.lookup_index_i;
                    lk_valid_d = 1'b1;
                    lk_tag_d   = bus.lookup_tag_i;
                end
            end
            default: begin
                // INIT and FLUSH share one clearing sweep; the counter parks at 0 on exit.
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = cnt_q;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            lk_valid_q <= 1'b0;
            lk_tag_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lk_valid_q <= lk_valid_d;
            lk_tag_q   <= lk_tag_d;
        end
    end

    tag_memory #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tag_memory (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .p0_en_i    (mem_en),
        .p0_we_i    (mem_we),
        .p0_addr_i  (mem_addr),
        .p0_wdata_i (mem_wdata),
        .p0_rdata_o (mem_rdata),
        .p1_en_i    (1'b0),
        .p1_addr_i  ('0),
        .p1_rdata_o (unused_p1_rdata)
    );

    always_comb begin
        rd_entry.valid = mem_rdata[TAG_SIZE];
        rd_entry.tag   = TAG_W_MAX'(mem_rdata[TAG_SIZE-1:0]);
    end

    assign bus.lookup_gnt_o   = lk_gnt;
    assign bus.update_gnt_o   = upd_gnt;
    assign bus.lookup_valid_o = lk_valid_q;
    assign bus.lookup_hit_o   = lk_valid_q && tag_hit(rd_entry, TAG_W_MAX'(lk_tag_q));
    assign bus.init_done_o    = (state_q != ST_INIT);
`ifdef TAG_CTRL_FLUSH_EN
    assign bus.flush_busy_o   = (state_q == ST_FLUSH);
`else
    assign bus.flush_busy_o   = 1'b0;
`endif
    assign state_o = state_q;

endmodule

// File: tb/tb_tag_memory_controller.sv
// Directed bench for tag_memory_controller (ADDR_WIDTH=4, TAG_SIZE=8); flush expectations follow TAG_CTRL_FLUSH_EN.
module tb_tag_memory_controller;
    import tag_ctrl_pkg::*;

    localparam int AW = 4;
    localparam int TS = 8;
`ifdef TAG_CTRL_FLUSH_EN
    localparam logic FLUSH_EN = 1'b1;
`else
    localparam logic FLUSH_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tag_memory_controller_if #(.ADDR_WIDTH(AW), .TAG_SIZE(TS)) bus ();
    tag_ctrl_state_e state;

    tag_memory_controller #(.ADDR_WIDTH(AW), .TAG_SIZE(TS)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave),
        .state_o (state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    task automatic idle();
        bus.lookup_req_i        = 1'b0;
        bus.lookup_index_i      = '0;
        bus.lookup_tag_i        = '0;
        bus.update_req_i        = 1'b0;
        bus.update_index_i      = '0;
        bus.update_tag_i        = '0;
        bus.update_invalidate_i = 1'b0;
        bus.flush_req_i         = 1'b0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic do_update(input int idx, input int tag, input logic inv);
        bus.update_req_i        = 1'b1;
        bus.update_index_i      = AW'(idx);
        bus.update_tag_i        = TS'(tag);
        bus.update_invalidate_i = inv;
        #1 check("upd_gnt", 32'(bus.update_gnt_o), 1);
        @(negedge clk);
        bus.update_req_i        = 1'b0;
        bus.update_invalidate_i = 1'b0;
    endtask

    task automatic do_lookup(input int idx, input int tag, input logic exp_hit);
        bus.lookup_req_i   = 1'b1;
        bus.lookup_index_i = AW'(idx);
        bus.lookup_tag_i   = TS'(tag);
        #1 check("lk_gnt", 32'(bus.lookup_gnt_o), 1);
        @(negedge clk);
        bus.lookup_req_i = 1'b0;
        check("lk_valid", 32'(bus.lookup_valid_o), 1);
        check("lk_hit", 32'(bus.lookup_hit_o), 32'(exp_hit));
    endtask

    initial begin
        int n;
        idle();
        bus.lookup_req_i = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_init_done", 32'(bus.init_done_o), 0);
        check("rst_lk_gnt", 32'(bus.lookup_gnt_o), 0);
        check("rst_upd_gnt", 32'(bus.update_gnt_o), 0);
        check("rst_lk_valid", 32'(bus.lookup_valid_o), 0);
        check("rst_flush_busy", 32'(bus.flush_busy_o), 0);
        check("rst_state", 32'(state), 32'(ST_INIT));

        // Power-up sweep: 16 cycles with no grants even though a lookup is waiting.
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("init_done_low", 32'(bus.init_done_o), 0);
            check("init_no_gnt", 32'(bus.lookup_gnt_o), 0);
            @(negedge clk);
        end
        check("init_done_high", 32'(bus.init_done_o), 1);
        check("state_ready", 32'(state), 32'(ST_READY));
        check("first_lk_gnt", 32'(bus.lookup_gnt_o), 1);
        @(negedge clk);
        bus.lookup_req_i = 1'b0;
        check("first_lk_valid", 32'(bus.lookup_valid_o), 1);
        check("cleared_entry_miss", 32'(bus.lookup_hit_o), 0);

        do_update(3, 'hA5, 1'b0);
        do_lookup(3, 'hA5, 1'b1);
        do_lookup(3, 'h5A, 1'b0);

        // Update and lookup in the same cycle: update wins, lookup follows and sees new data.
        bus.update_req_i   = 1'b1;
        bus.update_index_i = AW'(3);
        bus.update_tag_i   = TS'('h3C);
        bus.lookup_req_i   = 1'b1;
        bus.lookup_index_i = AW'(3);
        bus.lookup_tag_i   = TS'('h3C);
        #1 check("coll_upd_gnt", 32'(bus.update_gnt_o), 1);
        check("coll_lk_blocked", 32'(bus.lookup_gnt_o), 0);
        @(negedge clk);
        bus.update_req_i = 1'b0;
        #1 check("coll_lk_gnt", 32'(bus.lookup_gnt_o), 1);
        check("coll_no_valid", 32'(bus.lookup_valid_o), 0);
        @(negedge clk);
        bus.lookup_req_i = 1'b0;
        check("coll_valid", 32'(bus.lookup_valid_o), 1);
        check("coll_hit", 32'(bus.lookup_hit_o), 1);

        do_update(3, 'h00, 1'b1);
        do_lookup(3, 'hA5, 1'b0);
        do_lookup(3, 'h00, 1'b0);

        for (int i = 0; i < 16; i++) do_update(i, 'h10 + i, 1'b0);

        // Back-to-back lookups; odd indices carry the stored tag, even ones a wrong tag.
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                bus.lookup_req_i   = 1'b1;
                bus.lookup_index_i = AW'(i);
                bus.lookup_tag_i   = (i % 2 == 1) ? TS'('h10 + i) : TS'('hFF);
            end else begin
                bus.lookup_req_i = 1'b0;
            end
            #1;
            check("b2b_valid", 32'(bus.lookup_valid_o), 32'(i > 0));
            if (i > 0) begin
                if (exp_q.size() == 0) check("b2b_queue_underflow", 1, 0);
                else check("b2b_hit", 32'(bus.lookup_hit_o), 32'(exp_q.pop_front()));
            end
            if (i < 16) begin
                check("b2b_gnt", 32'(bus.lookup_gnt_o), 1);
                exp_q.push_back(1'(i % 2 == 1));
            end
            @(negedge clk);
        end
        check("b2b_drained", exp_q.size(), 0);

        // Flush coinciding with an update; a second flush pulse mid-sweep is ignored.
        bus.flush_req_i    = 1'b1;
        bus.update_req_i   = 1'b1;
        bus.update_index_i = AW'(5);
        bus.update_tag_i   = TS'('h77);
        #1 check("flush_upd_wait", 32'(bus.update_gnt_o), 32'(!FLUSH_EN));
        @(negedge clk);
        bus.flush_req_i = 1'b0;
        n = 0;
        while (bus.flush_busy_o && n < 40) begin
            check("flush_no_gnt", 32'(bus.update_gnt_o), 0);
            bus.flush_req_i = (n == 4);
            n++;
            @(negedge clk);
        end
        bus.flush_req_i = 1'b0;
        check("flush_busy_cycles", n, FLUSH_EN ? 16 : 0);
        #1 check("upd_after_flush", 32'(bus.update_gnt_o), 1);
        @(negedge clk);
        bus.update_req_i = 1'b0;
        do_lookup(5, 'h77, 1'b1);
        do_lookup(0, 'h10, !FLUSH_EN);
        do_lookup(15, 'h1F, !FLUSH_EN);

        // Lookup granted in the flush-request cycle still returns its result.
        do_update(1, 'h11, 1'b0);
        bus.flush_req_i    = 1'b1;
        bus.lookup_req_i   = 1'b1;
        bus.lookup_index_i = AW'(1);
        bus.lookup_tag_i   = TS'('h11);
        #1 check("flush_lk_gnt", 32'(bus.lookup_gnt_o), 1);
        @(negedge clk);
        bus.flush_req_i  = 1'b0;
        bus.lookup_req_i = 1'b0;
        check("flush_lk_valid", 32'(bus.lookup_valid_o), 1);
        check("flush_lk_hit", 32'(bus.lookup_hit_o), 1);
        check("flush_busy_on", 32'(bus.flush_busy_o), 32'(FLUSH_EN));
        n = 0;
        while (bus.flush_busy_o && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("flush2_busy_cycles", n, FLUSH_EN ? 16 : 0);

        // Reset just after a lookup grant discards the result.
        bus.lookup_req_i   = 1'b1;
        bus.lookup_index_i = AW'(5);
        bus.lookup_tag_i   = TS'('h77);
        @(posedge clk);
        #1 rst_n = 1'b0;
        bus.lookup_req_i = 1'b0;
        #1 check("rst_lk_discard", 32'(bus.lookup_valid_o), 0);
        check("rst_done_low", 32'(bus.init_done_o), 0);
        check("rst_state_init", 32'(state), 32'(ST_INIT));
        @(negedge clk);
        rst_n = 1'b1;

        // Reset again at sweep index 7; the sweep restarts from index 0.
        repeat (7) @(negedge clk);
        bus.lookup_req_i = 1'b1;
        rst_n = 1'b0;
        #1 check("mid_rst_state", 32'(state), 32'(ST_INIT));
        check("mid_rst_done", 32'(bus.init_done_o), 0);
        check("mid_rst_gnt", 32'(bus.lookup_gnt_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!bus.init_done_o && n < 40) begin
            check("resweep_no_gnt", 32'(bus.lookup_gnt_o), 0);
            n++;
            @(negedge clk);
        end
        check("resweep_cycles", n, 16);
        check("resweep_lk_gnt", 32'(bus.lookup_gnt_o), 1);
        @(negedge clk);
        bus.lookup_req_i = 1'b0;
        check("resweep_valid", 32'(bus.lookup_valid_o), 1);
        check("resweep_cleared", 32'(bus.lookup_hit_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tag_memory_controller.md
TAG_MEMORY_CONTROLLER -- requirements
Module: tag_memory_controller

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, cache index width (entries = 2**ADDR_WIDTH).
REQ-002 Parameter TAG_SIZE, default 20, tag width excluding valid bit.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 lookup_req_i  in  1  lookup request, held until granted.
REQ-006 lookup_index_i  in  ADDR_WIDTH  lookup index.
REQ-007 lookup_tag_i  in  TAG_SIZE  tag compared for hit.
REQ-008 lookup_gnt_o  out  1  lookup accepted this cycle.
REQ-009 lookup_valid_o  out  1  lookup result valid; one cycle after grant.
REQ-010 lookup_hit_o  out  1  entry valid and stored tag equals requested tag; meaningful only with lookup_valid_o.
REQ-011 update_req_i  in  1  write request, held until granted.
REQ-012 update_index_i  in  ADDR_WIDTH  write index.
REQ-013 update_tag_i  in  TAG_SIZE  tag to store.
REQ-014 update_invalidate_i  in  1  1: write invalid entry; 0: write valid entry with update_tag_i.
REQ-015 update_gnt_o  out  1  update written this cycle.
REQ-016 flush_req_i  in  1  single-cycle flush pulse.
REQ-017 flush_busy_o  out  1  flush sweep in progress.
REQ-018 init_done_o  out  1  power-up sweep complete; controller accepting requests.

Function
REQ-019 FSM states INIT, READY, FLUSH; INIT entered on reset.
REQ-020 INIT/FLUSH: sweep counter walks index 0..2**ADDR_WIDTH-1, one all-zero entry write per cycle; no grants issued.
REQ-021 INIT -> READY the cycle after the last index write; init_done_o rises with READY and stays high until reset.
REQ-022 READY: priority update > lookup; at most one memory-port access per cycle.
REQ-023 update granted combinationally in the cycle update_req_i is high in READY; write occurs at that clock edge.
REQ-024 lookup granted only when READY and no update_req_i; read issued at grant edge; lookup_valid_o high exactly the next cycle.
REQ-025 Lookup tag registered at grant; lookup_hit_o = stored valid AND stored tag == registered tag, combinational on memory read data.
REQ-026 Back-to-back lookups: one grant per cycle, one result per cycle, in order.
REQ-027 Update in cycle N then lookup of same index granted in N+1 returns the new entry.
REQ-028 Counter wrap: after index 2**ADDR_WIDTH-1 the sweep ends; counter never wraps back into a second pass.

Reset
REQ-029 rst_n_i low: state INIT, counter 0, lookup_valid_o 0, all grants 0, flush_busy_o 0, init_done_o 0.
REQ-030 Reset mid-sweep or mid-lookup: in-flight result discarded; sweep restarts at index 0 after release.

Configuration
REQ-031 Macro TAG_CTRL_FLUSH_EN defined: flush_req_i in READY -> FLUSH next cycle; flush_busy_o high throughout FLUSH; FLUSH -> READY after last index; a flush coinciding with update_req_i wins and the update waits.
REQ-032 flush_req_i during INIT or FLUSH ignored; lookup granted in the flush-request cycle still produces its result.
REQ-033 Macro undefined: FLUSH state absent, flush_req_i ignored, flush_busy_o tied 0.

Structure
REQ-034 Package tag_ctrl_pkg holds the FSM state enum and the tag entry struct {valid, tag}.
REQ-035 One sub-module: tag_memory instantiated internally, width TAG_SIZE+1 (valid MSB), read port 0 only, port 1 read tied off.

Verification (ADDR_WIDTH=4, TAG_SIZE=8)
REQ-036 Release reset -> init_done_o low 16 cycles, high cycle 17; no grants before.
REQ-037 Update idx 3 tag 0xA5, then lookup idx 3 tag 0xA5 -> valid next cycle, hit 1; tag 0x5A -> hit 0.
REQ-038 Update and lookup same cycle, idx 3 tag 0x3C -> update_gnt 1, lookup_gnt 0; lookup granted next cycle, hit 1.
REQ-039 Invalidate idx 3, lookup tag 0xA5 -> hit 0.
REQ-040 Fill idx 0..15, pulse flush -> flush_busy_o 16 cycles, then all lookups miss; without macro lookups still hit.
REQ-041 Assert rst_n_i at sweep index 7 -> outputs reset immediately; after release done after 16 further cycles.
